// File: rtl/bbox_stream_unit.sv
// Serial-fed triangle bounding box: 96-bit word in, clamped integer-pixel box out with cull/degen flags.
// Result valid 2 edges after the last accepted bit; ser_ready drops until bb_ready takes the result.
module bbox_stream_unit #(
   parameter int COORD_W  = 16,
   parameter int FRAC_W   = 6,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ser_in,
   input  logic                        ser_valid,
   output logic                        ser_ready,
   input  logic                        ser_clr,
   output logic                        bb_valid,
   input  logic                        bb_ready,
   output logic [COORD_W-FRAC_W-1:0]   xmin,
   output logic [COORD_W-FRAC_W-1:0]   xmax,
   output logic [COORD_W-FRAC_W-1:0]   ymin,
   output logic [COORD_W-FRAC_W-1:0]   ymax,
   output logic                        bb_cull,
   output logic                        bb_degen
);
   localparam int PIX_W  = COORD_W - FRAC_W;
   localparam int WORD_W = 6 * COORD_W;
   localparam int CNT_W  = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
   localparam logic [PIX_W:0]   XLIM     = (PIX_W+1)'(SCREEN_W - 1);
   localparam logic [PIX_W:0]   YLIM     = (PIX_W+1)'(SCREEN_H - 1);

   localparam logic [1:0] ST_SHIFT  = 2'd0;
   localparam logic [1:0] ST_MINMAX = 2'd1;
   localparam logic [1:0] ST_CLIP   = 2'd2;
   localparam logic [1:0] ST_OUT    = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WORD_W-1:0]  sr_q, sr_d;
   logic [COORD_W-1:0] xminfx_q, xminfx_d, xmaxfx_q, xmaxfx_d;
   logic [COORD_W-1:0] yminfx_q, yminfx_d, ymaxfx_q, ymaxfx_d;
   logic [PIX_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
   logic               cull_q, cull_d, degen_q, degen_d;
   logic [PIX_W:0]     xmin_int, xmax_int, ymin_int, ymax_int;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bounds are PIX_W+1 wide so a ceil of the largest coordinate cannot wrap before clamping.
   assign xmin_int = {1'b0, xminfx_q[COORD_W-1:FRAC_W]};
   assign ymin_int = {1'b0, yminfx_q[COORD_W-1:FRAC_W]};
   assign xmax_int = {1'b0, xmaxfx_q[COORD_W-1:FRAC_W]} + {{PIX_W{1'b0}}, |xmaxfx_q[FRAC_W-1:0]};
   assign ymax_int = {1'b0, ymaxfx_q[COORD_W-1:FRAC_W]} + {{PIX_W{1'b0}}, |ymaxfx_q[FRAC_W-1:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      xminfx_d = xminfx_q;
      xmaxfx_d = xmaxfx_q;
      yminfx_d = yminfx_q;
      ymaxfx_d = ymaxfx_q;
      xmin_d   = xmin_q;
      xmax_d   = xmax_q;
      ymin_d   = ymin_q;
      ymax_d   = ymax_q;
      cull_d   = cull_q;
      degen_d  = degen_q;
      case (state_q)
         ST_SHIFT: begin
            if (ser_clr) begin
               cnt_d = '0;
            end else if (ser_valid) begin
               sr_d = {ser_in, sr_q[WORD_W-1:1]};
               if (cnt_q == LAST_BIT) begin
                  cnt_d   = '0;
                  state_d = ST_MINMAX;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_MINMAX: begin
            xminfx_d = min3(sr_q[0*COORD_W +: COORD_W], sr_q[1*COORD_W +: COORD_W], sr_q[2*COORD_W +: COORD_W]);
            xmaxfx_d = max3(sr_q[0*COORD_W +: COORD_W], sr_q[1*COORD_W +: COORD_W], sr_q[2*COORD_W +: COORD_W]);
            yminfx_d = min3(sr_q[3*COORD_W +: COORD_W], sr_q[4*COORD_W +: COORD_W], sr_q[5*COORD_W +: COORD_W]);
            ymaxfx_d = max3(sr_q[3*COORD_W +: COORD_W], sr_q[4*COORD_W +: COORD_W], sr_q[5*COORD_W +: COORD_W]);
            state_d  = ST_CLIP;
         end
         ST_CLIP: begin
            xmin_d  = (xmin_int > XLIM) ? XLIM[PIX_W-1:0] : xmin_int[PIX_W-1:0];
            xmax_d  = (xmax_int > XLIM) ? XLIM[PIX_W-1:0] : xmax_int[PIX_W-1:0];
            ymin_d  = (ymin_int > YLIM) ? YLIM[PIX_W-1:0] : ymin_int[PIX_W-1:0];
            ymax_d  = (ymax_int > YLIM) ? YLIM[PIX_W-1:0] : ymax_int[PIX_W-1:0];
            cull_d  = (xmin_int > XLIM) | (ymin_int > YLIM);
            degen_d = (xminfx_q == xmaxfx_q) | (yminfx_q == ymaxfx_q);
            state_d = ST_OUT;
         end
         default: begin
            if (bb_ready) state_d = ST_SHIFT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_SHIFT;
         cnt_q    <= '0;
         sr_q     <= '0;
         xminfx_q <= '0;
         xmaxfx_q <= '0;
         yminfx_q <= '0;
         ymaxfx_q <= '0;
         xmin_q   <= '0;
         xmax_q   <= '0;
         ymin_q   <= '0;
         ymax_q   <= '0;
         cull_q   <= 1'b0;
         degen_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         xminfx_q <= xminfx_d;
         xmaxfx_q <= xmaxfx_d;
         yminfx_q <= yminfx_d;
         ymaxfx_q <= ymaxfx_d;
         xmin_q   <= xmin_d;
         xmax_q   <= xmax_d;
         ymin_q   <= ymin_d;
         ymax_q   <= ymax_d;
         cull_q   <= cull_d;
         degen_q  <= degen_d;
      end
   end

   assign ser_ready = (state_q == ST_SHIFT);
   assign bb_valid  = (state_q == ST_OUT);
   assign xmin      = xmin_q;
   assign xmax      = xmax_q;
   assign ymin      = ymin_q;
   assign ymax      = ymax_q;
   assign bb_cull   = cull_q;
   assign bb_degen  = degen_q;
endmodule

// File: tb/tb_bbox_stream_unit.sv
// Bench for bbox_stream_unit: directed and random triangles checked every cycle against a bit-level
// accumulator and an integer-arithmetic bounding-box model.
module tb_bbox_stream_unit;
   localparam int CW = 16;
   localparam int FW = 6;
   localparam int PW = CW - FW;
   localparam int SW = 640;
   localparam int SH = 480;
   localparam int WW = 6 * CW;

   typedef struct packed {
      logic [PW-1:0] xmin, xmax, ymin, ymax;
      logic          cull, degen;
   } box_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ser_in = 1'b0, ser_valid = 1'b0, ser_clr = 1'b0;
   logic ser_ready, bb_valid, bb_ready, bb_cull, bb_degen;
   logic [PW-1:0] xmin, xmax, ymin, ymax;
   box_t dut_box;
   int   rdy_mode = 0;
   logic rnd_bit = 1'b0;

   int n_chk = 0, n_fail = 0, cyc = 0, hs_cnt = 0;
   int mcnt = 0, done_edge = 0;
   bit busy = 1'b0;
   logic [WW-1:0] mword = '0;
   box_t exp_b = '0;

   always #5 clk = ~clk;

   bbox_stream_unit #(.COORD_W(CW), .FRAC_W(FW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
      .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
      .ser_clr(ser_clr), .bb_valid(bb_valid), .bb_ready(bb_ready), .xmin(xmin), .xmax(xmax),
      .ymin(ymin), .ymax(ymax), .bb_cull(bb_cull), .bb_degen(bb_degen)
   );

   assign dut_box  = {xmin, xmax, ymin, ymax, bb_cull, bb_degen};
   assign bb_ready = (rdy_mode == 0) || (rdy_mode == 2 && rnd_bit);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      #2 rnd_bit = 1'($urandom_range(0, 1));
   end

   function automatic int lim(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   // Reference: plain integer min/max, floor/ceil by division, then clamp.
   function automatic box_t ref_box(input logic [WW-1:0] w);
      int x[3], y[3];
      int xlo, xhi, ylo, yhi, fxl, fyl, cxh, cyh;
      box_t b;
      for (int k = 0; k < 3; k++) begin
         x[k] = int'(w[k*CW +: CW]);
         y[k] = int'(w[(k+3)*CW +: CW]);
      end
      xlo = x[0]; xhi = x[0]; ylo = y[0]; yhi = y[0];
      for (int k = 1; k < 3; k++) begin
         if (x[k] < xlo) xlo = x[k];
         if (x[k] > xhi) xhi = x[k];
         if (y[k] < ylo) ylo = y[k];
         if (y[k] > yhi) yhi = y[k];
      end
      fxl = xlo / (1 << FW);
      fyl = ylo / (1 << FW);
      cxh = (xhi + (1 << FW) - 1) / (1 << FW);
      cyh = (yhi + (1 << FW) - 1) / (1 << FW);
      b.cull  = (fxl > SW - 1) || (fyl > SH - 1);
      b.degen = (xlo == xhi) || (ylo == yhi);
      b.xmin  = PW'(lim(fxl, SW - 1));
      b.xmax  = PW'(lim(cxh, SW - 1));
      b.ymin  = PW'(lim(fyl, SH - 1));
      b.ymax  = PW'(lim(cyh, SH - 1));
      return b;
   endfunction

   function automatic box_t mkbox(input int a, b, c, d, input bit cu, dg);
      box_t r;
      r.xmin = PW'(a); r.xmax = PW'(b); r.ymin = PW'(c); r.ymax = PW'(d);
      r.cull = cu; r.degen = dg;
      return r;
   endfunction

   function automatic logic [WW-1:0] mkword(input logic [CW-1:0] x0, x1, x2, y0, y1, y2);
      return {y2, y1, y0, x2, x1, x0};
   endfunction

   task automatic chkbox(input string n, input box_t g, input box_t e);
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s @%0t: got x=%0d..%0d y=%0d..%0d cull=%0b degen=%0b, required x=%0d..%0d y=%0d..%0d cull=%0b degen=%0b",
                  n, $time, g.xmin, g.xmax, g.ymin, g.ymax, g.cull, g.degen,
                  e.xmin, e.xmax, e.ymin, e.ymax, e.cull, e.degen);
      end
   endtask

   task automatic chk1(input string n, input logic g, input logic e);
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0b, required %0b", n, $time, g, e);
      end
   endtask

   task automatic fail_timeout(input string n);
      n_chk++;
      n_fail++;
      $display("FAIL %s: timed out at %0t", n, $time);
   endtask

   // Compare process: checks current outputs, then advances the model by the coming edge.
   always @(negedge clk) begin
      bit ev;
      if (!rst_n) begin
         chkbox("reset_outputs", dut_box, '0);
         chk1("reset_bb_valid", bb_valid, 1'b0);
         chk1("reset_ser_ready", ser_ready, 1'b1);
         busy = 1'b0;
         mcnt = 0;
      end else begin
         ev = busy && (cyc >= done_edge + 2);
         chk1("bb_valid", bb_valid, ev);
         chk1("ser_ready", ser_ready, !busy);
         if (ev) chkbox("box", dut_box, exp_b);
         if (!busy) begin
            if (ser_clr) begin
               mcnt = 0;
            end else if (ser_valid) begin
               mword[mcnt] = ser_in;
               mcnt++;
               if (mcnt == WW) begin
                  busy      = 1'b1;
                  done_edge = cyc + 1;
                  exp_b     = ref_box(mword);
                  mcnt      = 0;
               end
            end
         end else if (ev && bb_ready) begin
            busy = 1'b0;
            hs_cnt++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [WW-1:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         int t;
         t = 0;
         ser_valid = 1'b1;
         ser_in    = w[i];
         while (!ser_ready && t < 400) begin
            step();
            t++;
         end
         if (!ser_ready) begin
            fail_timeout("ser_ready_wait");
            ser_valid = 1'b0;
            return;
         end
         step();
      end
      ser_valid = 1'b0;
   endtask

   task automatic wait_hs(input int target);
      int t;
      t = 0;
      while (hs_cnt < target && t < 3000) begin
         step();
         t++;
      end
      if (hs_cnt < target) fail_timeout("handshake_wait");
   endtask

   function automatic logic [CW-1:0] rcoord(input int lim_px);
      if ($urandom_range(0, 3) != 0) return CW'($urandom_range(0, lim_px * 64 - 1));
      return CW'($urandom_range(0, 65535));
   endfunction

   initial begin
      logic [WW-1:0] w1, w2, w3, w4, wr;
      int nw, hs0, t;
      nw = 0;
      w1 = mkword(16'h0280, 16'h0520, 16'h03D0, 16'h0140, 16'h0780, 16'h0330);
      w2 = mkword(16'h0280, 16'd64000, 16'h03D0, 16'h0140, 16'h0780, 16'h0330);
      w3 = mkword(16'd40960, 16'd44800, 16'd64032, 16'h0140, 16'h0780, 16'h0330);
      w4 = mkword(16'd6432, 16'd6432, 16'd6432, 16'h0140, 16'h0780, 16'h0330);
      wr = {$urandom, $urandom, $urandom};

      chkbox("model_basic",  ref_box(w1), mkbox(10, 21, 5, 30, 1'b0, 1'b0));
      chkbox("model_clamp",  ref_box(w2), mkbox(10, 639, 5, 30, 1'b0, 1'b0));
      chkbox("model_cull",   ref_box(w3), mkbox(639, 639, 5, 30, 1'b1, 1'b0));
      chkbox("model_degen",  ref_box(w4), mkbox(100, 101, 5, 30, 1'b0, 1'b1));

      repeat (3) step();
      rst_n = 1'b1;

      send_bits(w1, WW); nw++; wait_hs(nw);
      send_bits(w2, WW); nw++;
      send_bits(w3, WW); nw++; wait_hs(nw);

      // Held result with junk bits offered while the unit is busy.
      rdy_mode = 1;
      send_bits(w1, WW); nw++;
      t = 0;
      while (!bb_valid && t < 20) begin step(); t++; end
      if (!bb_valid) fail_timeout("backpressure_valid");
      for (int i = 0; i < 10; i++) begin
         ser_valid = 1'b1;
         ser_in    = 1'(i);
         step();
      end
      ser_valid = 1'b0;
      rdy_mode  = 0;
      send_bits(w4, WW); nw++; wait_hs(nw);

      // Resync: partial word then clear with a bit offered the same cycle.
      hs0 = hs_cnt;
      send_bits(wr, 50);
      ser_clr = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
      step();
      ser_clr = 1'b0; ser_valid = 1'b0;
      send_bits(w2, WW); nw++; wait_hs(nw);
      repeat (150) step();
      n_chk++;
      if (hs_cnt != hs0 + 1) begin
         n_fail++;
         $display("FAIL resync_one_result: got %0d results, required %0d", hs_cnt - hs0, 1);
      end

      // Reset in the middle of a word.
      send_bits(wr, 70);
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      send_bits(w1, WW); nw++; wait_hs(nw);

      rdy_mode = 0;
      for (int i = 0; i < 20; i++) begin
         send_bits(mkword(rcoord(SW), rcoord(SW), rcoord(SW), rcoord(SH), rcoord(SH), rcoord(SH)), WW);
         nw++;
      end
      wait_hs(nw);
      rdy_mode = 2;
      for (int i = 0; i < 15; i++) begin
         send_bits(mkword(rcoord(SW), rcoord(SW), rcoord(SW), rcoord(SH), rcoord(SH), rcoord(SH)), WW);
         nw++;
      end
      wait_hs(nw);
      repeat (5) step();
      n_chk++;
      if (hs_cnt != nw) begin
         n_fail++;
         $display("FAIL total_results: got %0d, required %0d", hs_cnt, nw);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
